// File: rtl/spi_frame_axis_packer.sv
// Packs 6-byte SPI transfers into sequence-numbered 64-bit AXI-Stream beats
// through a small frame FIFO, with packet framing (tlast) and sticky error flags.
module spi_frame_axis_packer #(
    parameter int FIFO_DEPTH        = 16,
    parameter int FRAMES_PER_PACKET = 64
) (
    input  logic                          i_clk,
    input  logic                          aresetn,
    input  logic [7:0]                    i_rx_byte,
    input  logic                          i_rx_byte_valid_tick,
    input  logic                          i_transfer_done_tick,
    output logic                          o_buffer_full,
    output logic [63:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic                          o_frame_err,
    input  logic                          i_clear_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (FRAMES_PER_PACKET > 1) ? $clog2(FRAMES_PER_PACKET) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PKT = PW'(FRAMES_PER_PACKET - 1);

    logic [2:0]    idx_q, idx_d;
    logic [47:0]   data_q, data_d;
    logic [15:0]   seq_q, seq_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, err_q, err_d;
    logic [64:0]   mem_q [FIFO_DEPTH];

    logic        byte_ok, byte_extra;
    logic [2:0]  cnt;
    logic        frame_done, frame_bad;
    logic        pop, push, drop, tlast_in;
    logic [64:0] rd_word;

    // A byte arriving with the done tick still belongs to this transfer,
    // so completion is judged on the post-byte count and post-byte data.
    assign byte_ok    = i_rx_byte_valid_tick && (idx_q < 3'd6);
    assign byte_extra = i_rx_byte_valid_tick && (idx_q == 3'd6);
    assign cnt        = idx_q + {2'b00, byte_ok};
    assign frame_done = i_transfer_done_tick && (cnt == 3'd6);
    assign frame_bad  = i_transfer_done_tick && (cnt != 3'd6);

    always_comb begin
        data_d = data_q;
        for (int s = 0; s < 6; s++) begin
            if (byte_ok && idx_q == 3'(s)) data_d[8*(5-s) +: 8] = i_rx_byte;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (i_transfer_done_tick) idx_d = 3'd0;
        else if (byte_ok)         idx_d = idx_q + 3'd1;
    end

    // A full FIFO can still accept a frame when the head leaves in the same cycle.
    assign pop      = (level_q != '0) && m_axis_tready;
    assign push     = frame_done && ((level_q != FULL_LVL) || pop);
    assign drop     = frame_done && !push;
    assign tlast_in = (pkt_q == LAST_PKT);

    always_comb begin
        seq_d    = frame_done ? seq_q + 16'd1 : seq_q;
        pkt_d    = pkt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            pkt_d    = tlast_in ? '0 : pkt_q + PW'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Set wins over clear when both land on the same cycle.
    assign ovf_d = drop | (ovf_q & ~i_clear_flags);
    assign err_d = byte_extra | frame_bad | (err_q & ~i_clear_flags);

    always_ff @(posedge i_clk or negedge aresetn) begin
        if (!aresetn) begin
            idx_q    <= '0;
            data_q   <= '0;
            seq_q    <= '0;
            pkt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            data_q   <= data_d;
            seq_q    <= seq_d;
            pkt_q    <= pkt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: the read side is masked whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {seq_q, data_d, tlast_in};
    end

    assign rd_word       = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? rd_word[64:1] : 64'd0;
    assign m_axis_tlast  = m_axis_tvalid & rd_word[0];
    assign o_fifo_level  = level_q;
    assign o_buffer_full = (level_q == FULL_LVL);
    assign o_overflow    = ovf_q;
    assign o_frame_err   = err_q;

endmodule

// File: tb/tb_spi_frame_axis_packer.sv
// Directed bench: stimulus pushes expected beats into a queue, an independent
// monitor pops and compares each accepted AXI-Stream beat.
module tb_spi_frame_axis_packer;

    localparam int DEPTH = 4;
    localparam int FPP   = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  rx_byte;
    logic        rx_valid, done, clr;
    logic        buf_full, tvalid, tready, tlast, ovf, ferr;
    logic [63:0] tdata;
    logic [2:0]  level;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;
    logic [15:0] exp_seq;
    int          exp_pkt;

    always #5 clk = ~clk;

    spi_frame_axis_packer #(.FIFO_DEPTH(DEPTH), .FRAMES_PER_PACKET(FPP)) dut (
        .i_clk(clk), .aresetn(aresetn), .i_rx_byte(rx_byte),
        .i_rx_byte_valid_tick(rx_valid), .i_transfer_done_tick(done),
        .o_buffer_full(buf_full), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .o_fifo_level(level),
        .o_overflow(ovf), .o_frame_err(ferr), .i_clear_flags(clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (aresetn && tvalid && tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL axis_unexpected: got %h/%b expected no beat", tdata, tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if ({tdata, tlast} !== mon_e) begin
                    n_fail++;
                    $display("FAIL axis_beat: got %h/%b expected %h/%b",
                             tdata, tlast, mon_e[64:1], mon_e[0]);
                end
            end
        end
    end

    task automatic reset_dut(input bit chk_outs);
        aresetn = 1'b0;
        #2;
        if (chk_outs) begin
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tlast", tlast, 0);
            chk("rst_tdata", tdata, 0);
            chk("rst_full", buf_full, 0);
            chk("rst_level", level, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_err", ferr, 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) aresetn = 1'b1;
        @(posedge clk); #1;
        exp_seq = 16'd0;
        exp_pkt = 0;
    endtask

    // n bytes base, base+1, ...; done rides on the last byte.
    task automatic send(input int n, input logic [7:0] base, input bit pushed,
                        input bit pop_last, input bit clr_last);
        logic [47:0] d;
        d = '0;
        for (int i = 0; i < n; i++) begin
            rx_byte  = base + 8'(i);
            rx_valid = 1'b1;
            done     = (i == n - 1);
            if (i == n - 1 && pop_last) tready = 1'b1;
            if (i == n - 1 && clr_last) clr = 1'b1;
            if (i < 6) d[8*(5-i) +: 8] = rx_byte;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        done     = 1'b0;
        clr      = 1'b0;
        if (pop_last) tready = 1'b0;
        if (n >= 6) begin
            if (pushed) begin
                exp_q.push_back({exp_seq, d, exp_pkt == FPP - 1});
                exp_pkt = (exp_pkt + 1) % FPP;
            end
            exp_seq = exp_seq + 16'd1;
        end
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic drain();
        tready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_level", level, 0);
    endtask

    initial begin
        rx_byte = 8'h00; rx_valid = 1'b0; done = 1'b0; clr = 1'b0; tready = 1'b0;
        reset_dut(1'b1);

        // Single frame 01..06, consumed immediately
        tready = 1'b1;
        send(6, 8'h01, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_level1", level, 1);
        chk("single_tvalid", tvalid, 1);
        @(negedge clk);
        chk("single_level0", level, 0);

        // Two packets of four frames, tlast on seq 3 and 7
        reset_dut(1'b0);
        tready = 1'b1;
        for (int f = 0; f < 8; f++) send(6, 8'(8'h10 + 8'(f * 6)), 1'b1, 1'b0, 1'b0);
        drain();

        // Fill, overflow, then push coincident with pop at full
        reset_dut(1'b0);
        tready = 1'b0;
        for (int f = 0; f < 4; f++) send(6, 8'(8'h80 + 8'(f * 8)), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("fill_full", buf_full, 1);
        chk("fill_level", level, 4);
        chk("fill_no_ovf", ovf, 0);
        send(6, 8'hA0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_ovf", ovf, 1);
        chk("drop_level", level, 4);
        pulse_clear();
        @(negedge clk);
        chk("ovf_cleared", ovf, 0);
        send(6, 8'hC0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("pushpop_level", level, 4);
        chk("pushpop_full", buf_full, 1);
        chk("pushpop_no_ovf", ovf, 0);
        drain();

        // Short transfer with coincident clear, then an over-long transfer
        send(5, 8'h20, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("short_err", ferr, 1);
        chk("short_level", level, 0);
        pulse_clear();
        @(negedge clk);
        chk("err_cleared", ferr, 0);
        send(7, 8'h30, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("extra_err", ferr, 1);
        drain();

        // Reset in the middle of a transfer
        for (int i = 0; i < 3; i++) begin
            rx_byte = 8'hE0 + 8'(i); rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        reset_dut(1'b1);
        tready = 1'b1;
        send(6, 8'h41, 1'b1, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
